// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder
//   Frame sequencer in front of the FFT core data input. A frame request pulses the
//   FFT config stage and waits for its handshake. It then forwards exactly FRAME_LEN
//   upstream samples to the FFT data stream, with tlast on the final beat, so the
//   config beat always reaches the core before the data beats.
//
// Parameters
//   DATA_W     sample width (packed re/im)
//   FRAME_LEN  samples per frame, >= 2
//
// Ports
//   aclk, aresetn                   clock, asynchronous active-low reset
//   frame_start, fwd_inv_in         frame request and direction (1=fwd), sampled in IDLE
//   cfg_start, cfg_fwd_inv          config pulse and latched direction
//   cfg_done                        config beat accepted by the FFT core
//   s_axis_t{data,valid,ready,last} upstream sample stream
//   m_axis_t{data,valid,ready,last} FFT data stream, registered outputs
//   busy                            high in every state except IDLE
//   frame_done                      pulse when the tlast beat is accepted downstream
//
// Build option
//   FFT_ZERO_PAD_EN  An upstream tlast that arrives before beat FRAME_LEN-1 ends the
//                    input early. The rest of the frame is then filled with zero samples.
//                    When FFT_ZERO_PAD_EN is undefined, s_axis_tlast is ignored.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for frame_start
// CFG    | cfg_start issued, waiting for cfg_done
// STREAM | accepting upstream samples into the skid buffer
// PAD    | injecting zero samples after an early upstream tlast (option only)
// DRAIN  | input closed, waiting for the tlast beat to leave downstream

module fft_frame_feeder #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 1024
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              frame_start,
    input  logic              fwd_inv_in,
    output logic              cfg_start,
    output logic              cfg_fwd_inv,
    input  logic              cfg_done,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_STREAM = 3'd2,
`ifdef FFT_ZERO_PAD_EN
        S_PAD    = 3'd3,
`endif
        S_DRAIN  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               fwd_inv_q, fwd_inv_d;
    logic               cfg_start_q, cfg_start_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Two-entry skid buffer. Entry 0 is the head and drives m_axis directly.
    logic [DATA_W-1:0]  e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic               e0_last_q, e0_last_d, e1_last_q, e1_last_d;
    logic [1:0]         fill_q, fill_d;

    logic               full;
    logic               pop;
    logic               push;
    logic [DATA_W-1:0]  push_data;
    logic               push_last;
    logic               s_ready;

`ifndef FFT_ZERO_PAD_EN
    logic unused_s_tlast;
    assign unused_s_tlast = s_axis_tlast;
`endif

    assign full    = (fill_q == 2'd2);
    assign pop     = m_axis_tvalid & m_axis_tready;
    assign s_ready = (state_q == S_STREAM) & ~full;

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = (fill_q != 2'd0);
    assign m_axis_tdata  = e0_data_q;
    assign m_axis_tlast  = e0_last_q;
    assign cfg_start     = cfg_start_q;
    assign cfg_fwd_inv   = fwd_inv_q;
    assign busy          = (state_q != S_IDLE);

    // Sequencer: next state, sample counter and skid write request.
    always_comb begin
        state_d     = state_q;
        fwd_inv_d   = fwd_inv_q;
        cfg_start_d = 1'b0;
        count_d     = count_q;
        push        = 1'b0;
        push_data   = s_axis_tdata;
        push_last   = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d     = S_CFG;
                    fwd_inv_d   = fwd_inv_in;
                    cfg_start_d = 1'b1;
                    count_d     = '0;
                end
            end
            S_CFG: begin
                if (cfg_done) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (s_axis_tvalid && s_ready) begin
                    push      = 1'b1;
                    push_last = (count_q == LAST_IDX);
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        count_d = count_q + 1'b1;
`ifdef FFT_ZERO_PAD_EN
                        if (s_axis_tlast) state_d = S_PAD;
`endif
                    end
                end
            end
`ifdef FFT_ZERO_PAD_EN
            S_PAD: begin
                push_data = '0;
                if (!full) begin
                    push      = 1'b1;
                    push_last = (count_q == LAST_IDX);
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if (pop && m_axis_tlast) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Skid buffer update. A push never arrives while full, so the full case only drains.
    always_comb begin
        e0_data_d = e0_data_q;
        e0_last_d = e0_last_q;
        e1_data_d = e1_data_q;
        e1_last_d = e1_last_q;
        fill_d    = fill_q;

        unique case (fill_q)
            2'd0: begin
                if (push) begin
                    e0_data_d = push_data;
                    e0_last_d = push_last;
                    fill_d    = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    e0_data_d = push_data;
                    e0_last_d = push_last;
                end else if (push) begin
                    e1_data_d = push_data;
                    e1_last_d = push_last;
                    fill_d    = 2'd2;
                end else if (pop) begin
                    fill_d    = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    e0_data_d = e1_data_q;
                    e0_last_d = e1_last_q;
                    fill_d    = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            fwd_inv_q   <= 1'b0;
            cfg_start_q <= 1'b0;
            count_q     <= '0;
            e0_data_q   <= '0;
            e0_last_q   <= 1'b0;
            e1_data_q   <= '0;
            e1_last_q   <= 1'b0;
            fill_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            fwd_inv_q   <= fwd_inv_d;
            cfg_start_q <= cfg_start_d;
            count_q     <= count_d;
            e0_data_q   <= e0_data_d;
            e0_last_q   <= e0_last_d;
            e1_data_q   <= e1_data_d;
            e1_last_q   <= e1_last_d;
            fill_q      <= fill_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Testbench for fft_frame_feeder with FRAME_LEN=8. Upstream samples are random and
// the sink stall patterns vary per frame. Each frame's expected output is derived
// from the samples handed to the DUT: they must come out in order, with tlast only
// on the eighth beat. Zero padding is added when FFT_ZERO_PAD_EN is defined.

module tb_fft_frame_feeder;

    localparam int DW = 32;
    localparam int FL = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          frame_start = 1'b0;
    logic          fwd_inv_in = 1'b0;
    logic          cfg_start;
    logic          cfg_fwd_inv;
    logic          cfg_done = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic          busy;
    logic          frame_done;

    fft_frame_feeder #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .frame_start(frame_start), .fwd_inv_in(fwd_inv_in),
        .cfg_start(cfg_start), .cfg_fwd_inv(cfg_fwd_inv), .cfg_done(cfg_done),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Upstream source and config-stage environment.
    logic [DW-1:0] src[$];
    int            src_idx, src_limit, tlast_idx;
    bit            sent;
    int            src_mode, sink_mode;
    int            cfg_delay, cfg_cnt;
    bit            cfg_given;
    bit            exp_fwd;
    bit            start_req, fs_in_stream, fs_on_done;

    // Observations.
    logic [DW-1:0] obs_d[$];
    logic          obs_l[$];
    int            obs_c[$];
    int            cyc_n = 0;
    int            cfg_pulses, done_pulses, done_at;
    int            cfg_done_cyc, first_rdy_cyc;
    bit            hold_v;
    logic [DW:0]   hold_val;

    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        bit cfg_now;
        @(negedge aclk);
        cyc_n++;
        if (sent) begin
            s_axis_tvalid = 1'b0;
            sent = 1'b0;
        end
        cfg_now = 1'b0;
        cfg_done = 1'b0;
        if (cfg_start) begin
            cfg_pulses++;
            cfg_cnt = cfg_delay;
        end
        if (cfg_cnt == 0) begin
            cfg_done = 1'b1;
            cfg_now = 1'b1;
            cfg_cnt = -1;
            cfg_done_cyc = cyc_n;
        end else if (cfg_cnt > 0) begin
            cfg_cnt--;
        end
        frame_start = start_req;
        start_req = 1'b0;
        case (sink_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = cyc_n[0];
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        if (!s_axis_tvalid && src_idx < src_limit && src_idx < src.size() &&
            (src_mode == 0 || $urandom_range(0, 2) != 0)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src[src_idx];
            s_axis_tlast  = (src_idx == tlast_idx);
        end
        #1;
        if (hold_v) begin
            chk("stall_valid_held", m_axis_tvalid, 1'b1);
            chk("stall_data_held", {m_axis_tlast, m_axis_tdata}, hold_val);
        end
        if (!cfg_given) chk("quiet_before_cfg_done", {s_axis_tready, m_axis_tvalid}, 2'b00);
        if (cfg_now) chk("cfg_fwd_inv", cfg_fwd_inv, exp_fwd);
        if (s_axis_tready && first_rdy_cyc < 0) first_rdy_cyc = cyc_n;
        if (m_axis_tvalid && m_axis_tready) begin
            obs_d.push_back(m_axis_tdata);
            obs_l.push_back(m_axis_tlast);
            obs_c.push_back(cyc_n);
        end
        hold_v   = m_axis_tvalid && !m_axis_tready;
        hold_val = {m_axis_tlast, m_axis_tdata};
        if (frame_done) begin
            done_pulses++;
            done_at = obs_d.size();
        end
        if (s_axis_tvalid && s_axis_tready) begin
            src_idx++;
            sent = 1'b1;
        end
        if (fs_in_stream && s_axis_tready) begin
            frame_start = 1'b1;
            fs_in_stream = 1'b0;
        end
        if (fs_on_done && frame_done) begin
            frame_start = 1'b1;
            fs_on_done = 1'b0;
        end
        if (cfg_now) cfg_given = 1'b1;
        @(posedge aclk);
    endtask

    task automatic start_frame(input bit fwd, input int delay, input int snk, input int srcm);
        obs_d.delete(); obs_l.delete(); obs_c.delete();
        src_idx = 0; src_limit = src.size(); sent = 1'b0;
        cfg_pulses = 0; done_pulses = 0; done_at = -1;
        cfg_cnt = -1; cfg_given = 1'b0; cfg_delay = delay;
        first_rdy_cyc = -1; cfg_done_cyc = -1; hold_v = 1'b0;
        sink_mode = snk; src_mode = srcm;
        fwd_inv_in = fwd; exp_fwd = fwd;
        start_req = 1'b1;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && done_pulses == 0; i++) cyc();
        chk("frame_timeout", done_pulses > 0, 1'b1);
    endtask

    task automatic check_frame(input bit b2b);
        int data_bad, last_bad;
        data_bad = 0;
        last_bad = 0;
        chk("beat_count", obs_d.size(), FL);
        for (int i = 0; i < FL && i < obs_d.size(); i++) begin
            if (obs_d[i] !== exp_q[i]) data_bad++;
            if (obs_l[i] !== (i == FL - 1)) last_bad++;
        end
        chk("data_order_errors", data_bad, 0);
        chk("tlast_position_errors", last_bad, 0);
        chk("cfg_start_pulses", cfg_pulses, 1);
        chk("frame_done_pulses", done_pulses, 1);
        chk("frame_done_on_tlast_beat", done_at, FL);
        if (b2b && obs_c.size() == FL) chk("back_to_back_span", obs_c[FL-1] - obs_c[0], FL - 1);
        @(negedge aclk);
        #1;
        chk("idle_after_frame", {busy, cfg_start}, 2'b00);
    endtask

    task automatic fill_random(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back($urandom);
        tlast_idx = -1;
    endtask

    task automatic pulse_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        sent = 1'b0;
        cfg_done = 1'b0;
        frame_start = 1'b0;
        #1;
        chk("reset_outputs_zero",
            {cfg_start, cfg_fwd_inv, s_axis_tready, m_axis_tvalid, m_axis_tdata,
             m_axis_tlast, busy, frame_done}, '0);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        tlast_idx = -1;
        src_limit = 0;
        src_idx = 0;
        sent = 1'b0;
        cfg_cnt = -1;
        start_req = 1'b0;
        fs_in_stream = 1'b0;
        fs_on_done = 1'b0;

        // Power-on reset
        #2;
        chk("por_outputs_zero",
            {cfg_start, cfg_fwd_inv, s_axis_tready, m_axis_tvalid, m_axis_tdata,
             m_axis_tlast, busy, frame_done}, '0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;

        // Frame 1: samples 1..8, forward, cfg_done 3 cycles after cfg_start, no stalls
        src.delete();
        for (int i = 1; i <= FL; i++) src.push_back(DW'(i));
        tlast_idx = -1;
        exp_q = src;
        start_frame(1'b1, 3, 0, 0);
        run_until_done(100);
        check_frame(1'b1);

        // Frame 2: inverse, toggling sink, bursty source
        fill_random(FL);
        exp_q = src;
        start_frame(1'b0, 2, 1, 1);
        run_until_done(200);
        check_frame(1'b0);

        // cfg_done while idle must not start anything
        @(negedge aclk);
        cfg_done = 1'b1;
        @(negedge aclk);
        cfg_done = 1'b0;
        #1;
        chk("cfg_done_in_idle_ignored", {busy, cfg_start}, 2'b00);

        // Frame 3: frame_start during STREAM and on the frame_done cycle, random sink
        fill_random(FL);
        exp_q = src;
        start_frame(1'b1, 1, 2, 1);
        fs_in_stream = 1'b1;
        fs_on_done = 1'b1;
        run_until_done(200);
        check_frame(1'b0);

        // Frame 4: reset after beat 4 accepted, then a clean frame
        fill_random(FL);
        start_frame(1'b1, 3, 0, 0);
        for (int i = 0; i < 100 && src_idx < 4; i++) cyc();
        chk("abort_reached_beat4", src_idx, 4);
        pulse_reset();
        fill_random(FL);
        exp_q = src;
        start_frame(1'b0, 3, 2, 1);
        run_until_done(200);
        check_frame(1'b0);

        // Frame 5: cfg_done in the same cycle as cfg_start
        fill_random(FL);
        exp_q = src;
        start_frame(1'b1, 0, 0, 0);
        run_until_done(100);
        chk("ready_one_cycle_after_cfg_done", first_rdy_cyc - cfg_done_cyc, 1);
        check_frame(1'b0);

        // Frame 6: early upstream tlast on the 5th sample
`ifdef FFT_ZERO_PAD_EN
        fill_random(5);
        tlast_idx = 4;
        exp_q = src;
        for (int i = 0; i < FL - 5; i++) exp_q.push_back('0);
        start_frame(1'b1, 2, 0, 0);
        run_until_done(100);
        check_frame(1'b0);
`else
        fill_random(FL);
        tlast_idx = 4;
        exp_q = src;
        start_frame(1'b1, 2, 0, 0);
        src_limit = 5;
        for (int i = 0; i < 40; i++) cyc();
        chk("no_pad_still_busy", busy, 1'b1);
        chk("no_pad_beats_so_far", obs_d.size(), 5);
        chk("no_pad_no_early_done", done_pulses, 0);
        src_limit = FL;
        run_until_done(100);
        check_frame(1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
